phase1_mem_responder: RTL and testbench
=======================================

// Module: phase1_mem_responder
// PURPOSE
//   Responder end of the phase-1 request/response channel. The phase-1 bench initiates
//   read/write requests; this block accepts them, holds each one for a programmable
//   number of wait states, then updates or reads a local word-addressed memory and returns
//   a response with valid/ready. One transaction is in flight at a time.
// PARAMETERS
//   ADDR_W       8   request address width
//   DATA_W       32  data width
//   DEPTH        64  memory words; must be a power of 2 and <= 2**ADDR_W
//   WAIT_CYCLES  2   wait-state cycles between accept and response (0 allowed)
// PORTS
//   clk        in   1       single clock, all logic on rising edge
//   reset      in   1       synchronous, active-high
//   req_valid  in   1       request present
//   req_ready  out  1       responder idle, can accept a request
//   req_write  in   1       1=write, 0=read
//   req_addr   in   ADDR_W  word address
//   req_wdata  in   DATA_W  write data
//   rsp_valid  out  1       response present
//   rsp_ready  in   1       initiator accepts the response
//   rsp_rdata  out  DATA_W  read data (0 for writes)
//   rsp_err    out  1       address error (only with PHASE1_ADDR_CHECK_EN)
//   busy       out  1       high in any state other than IDLE
// BEHAVIOUR
//   - Reset values: req_ready=1 from the first cycle after reset is released;
//     rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0; all memory words cleared to 0;
//     FSM=IDLE; wait counter=0.
//   - FSM states:
//     - IDLE: req_ready=1.
//     - WAIT: counts WAIT_CYCLES.
//     - RESP: rsp_valid=1.
//   - Accept: req_valid&&req_ready at edge N latches write, addr and wdata. The FSM goes
//     to WAIT, or straight to RESP if WAIT_CYCLES==0.
//   - WAIT exit: on the last WAIT cycle the write is committed, or the read data is
//     sampled into rsp_rdata. rsp_valid rises at edge N+1+WAIT_CYCLES.
//   - RESP: rsp_valid, rsp_rdata and rsp_err hold stable until rsp_valid&&rsp_ready.
//     On that edge rsp_valid drops and the FSM returns to IDLE. req_ready rises the same
//     edge, so the next accept is possible one cycle after the response handshake.
//     req_ready is never high in the same cycle as rsp_valid.
//   - req_* inputs are ignored outside IDLE. rsp_ready is ignored outside RESP.
//   - Write response: rsp_rdata=0, rsp_err per address check.
//   - Read of a never-written word returns 0.
//   - Reset mid-operation:
//     - Aborts the transaction; the FSM goes to IDLE on that edge.
//     - A write not yet committed (still in WAIT) is discarded.
//     - Memory is cleared.
//     - rsp_valid drops on the reset edge; no response is issued for the aborted request.
//   - Memory index = req_addr[$clog2(DEPTH)-1:0].
// CONFIGURATION
//   PHASE1_ADDR_CHECK_EN defined:
//     - A request with req_addr >= DEPTH is an address error.
//     - A write is suppressed; a read returns rsp_rdata=0.
//     - rsp_err=1 in that response; the response timing is unchanged.
//   PHASE1_ADDR_CHECK_EN undefined:
//     - Addresses alias modulo DEPTH.
//     - rsp_err is tied to 0.
// TESTING
//   1. Reset held 1 cycle -> next cycle: req_ready=1, rsp_valid=0, busy=0.
//      Then read addr 0 -> rsp_rdata=0.
//   2. WAIT_CYCLES=2: write 0xDEADBEEF to addr 5, accepted at edge N ->
//      rsp_valid at N+3, rsp_rdata=0. Then read addr 5 -> rsp_rdata=0xDEADBEEF.
//   3. Read with rsp_ready low for 4 cycles after rsp_valid -> rsp_valid/rsp_rdata stable
//      4 cycles, req_ready=0 throughout. req_ready rises at the handshake edge.
//   4. WAIT_CYCLES=0: back-to-back writes to addrs 1,2 with rsp_ready=1 ->
//      each response 1 cycle after accept; accepts 2 cycles apart.
//   5. DEPTH=64: write 0x12345678 to addr 70, then read addr 6.
//      - With PHASE1_ADDR_CHECK_EN: rsp_err=1 on the write; addr 6 reads 0.
//      - Without it: rsp_err=0; addr 6 reads 0x12345678.
//   6. Write 0xA5A5A5A5 to addr 3; assert reset during WAIT -> no rsp_valid.
//      After reset, read addr 3 -> 0.

Source files
------------

// File: rtl/phase1_mem_responder_if.sv
// Phase-1 request/response channel between initiator and responder.
// master: drives req_*/rsp_ready; slave: drives req_ready/rsp_*.
interface phase1_mem_responder_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/phase1_mem_responder.sv
// Phase-1 memory responder: accepts one request, waits WAIT_CYCLES,
// commits/reads a local word memory, returns a held response.
// Ports: clk, reset (sync, active-high), bus (slave modport), busy.
// Optional: define PHASE1_ADDR_CHECK_EN to flag req_addr >= DEPTH.
module phase1_mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  phase1_mem_responder_if.slave  bus,
  output logic                   busy
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic              accept, commit;
  logic              l_write, l_err;
  logic [IW-1:0]     l_idx;
  logic [DATA_W-1:0] l_wdata;
  logic              in_err;
  logic              c_write, c_err;
  logic [IW-1:0]     c_idx;
  logic [DATA_W-1:0] c_wdata;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [DATA_W-1:0] mem [DEPTH];

`ifdef PHASE1_ADDR_CHECK_EN
  assign in_err = {1'b0, bus.req_addr} >= (ADDR_W+1)'(DEPTH);
`else
  assign in_err = 1'b0;
`endif

  assign accept = (state == IDLE) && bus.req_valid;

  // With zero wait states the commit happens on the accept edge,
  // straight from the request inputs; otherwise from the latched copy.
  assign c_write = (state == IDLE) ? bus.req_write : l_write;
  assign c_err   = (state == IDLE) ? in_err : l_err;
  assign c_idx   = (state == IDLE) ? bus.req_addr[IW-1:0] : l_idx;
  assign c_wdata = (state == IDLE) ? bus.req_wdata : l_wdata;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    commit  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (WAIT_CYCLES == 0) begin
            commit  = 1'b1;
            state_n = RESP;
          end else begin
            state_n = WAIT;
            cnt_n   = '0;
          end
        end
      end
      WAIT: begin
        if (cnt == CW'(WAIT_CYCLES - 1)) begin
          commit  = 1'b1;
          state_n = RESP;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      l_write <= 1'b0;
      l_err   <= 1'b0;
      l_idx   <= '0;
      l_wdata <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        l_write <= bus.req_write;
        l_err   <= in_err;
        l_idx   <= bus.req_addr[IW-1:0];
        l_wdata <= bus.req_wdata;
      end
      if (commit) begin
        if (c_write && !c_err) mem[c_idx] <= c_wdata;
        rdata_q <= (c_write || c_err) ? '0 : mem[c_idx];
        err_q   <= c_err;
      end
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign busy          = (state != IDLE);
endmodule

// File: tb/tb_phase1_mem_responder.sv
// Bench for phase1_mem_responder: two DUTs (2 and 0 wait states)
// share stimulus and are checked every cycle against a timing model.
module tb_phase1_mem_responder;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          req_valid, req_write, rsp_ready;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          busy0, busy1;

  phase1_mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus0();
  phase1_mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus1();

  assign bus0.req_valid = req_valid;
  assign bus0.req_write = req_write;
  assign bus0.req_addr  = req_addr;
  assign bus0.req_wdata = req_wdata;
  assign bus0.rsp_ready = rsp_ready;
  assign bus1.req_valid = req_valid;
  assign bus1.req_write = req_write;
  assign bus1.req_addr  = req_addr;
  assign bus1.req_wdata = req_wdata;
  assign bus1.rsp_ready = rsp_ready;

  phase1_mem_responder #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .WAIT_CYCLES(2)
  ) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave), .busy(busy0));

  phase1_mem_responder #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .WAIT_CYCLES(0)
  ) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave), .busy(busy1));

  logic          o_ready [2];
  logic          o_valid [2];
  logic          o_busy  [2];
  logic          o_err   [2];
  logic [DW-1:0] o_rdata [2];
  assign o_ready[0] = bus0.req_ready;
  assign o_valid[0] = bus0.rsp_valid;
  assign o_busy[0]  = busy0;
  assign o_err[0]   = bus0.rsp_err;
  assign o_rdata[0] = bus0.rsp_rdata;
  assign o_ready[1] = bus1.req_ready;
  assign o_valid[1] = bus1.rsp_valid;
  assign o_busy[1]  = busy1;
  assign o_err[1]   = bus1.rsp_err;
  assign o_rdata[1] = bus1.rsp_rdata;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail(string nm);
    n_vec++;
    n_bad++;
    $display("FAIL %s: got timeout expected response", nm);
  endtask

  function automatic bit oor(int a);
`ifdef PHASE1_ADDR_CHECK_EN
    return a >= DEPTH;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int wc(int k);
    return (k == 0) ? 2 : 0;
  endfunction

  // Transaction-level model: an accepted request completes exactly
  // wc(k) edges later; the response is held until rsp_ready.
  logic [DW-1:0] m_mem [2][DEPTH];
  bit            pend [2];
  bit            resp [2];
  bit            p_write [2];
  int            p_addr [2];
  logic [DW-1:0] p_data [2];
  int            due [2];
  logic [DW-1:0] e_rdata [2];
  bit            e_err [2];
  int            cyc = 0;
  bit            armed = 1'b0;

  always @(posedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        for (int i = 0; i < DEPTH; i++) m_mem[k][i] = '0;
        pend[k] = 1'b0;
        resp[k] = 1'b0;
      end else begin
        automatic bit was_idle = !pend[k] && !resp[k];
        if (resp[k] && rsp_ready) resp[k] = 1'b0;
        if (was_idle && req_valid) begin
          pend[k]    = 1'b1;
          p_write[k] = req_write;
          p_addr[k]  = int'(req_addr);
          p_data[k]  = req_wdata;
          due[k]     = cyc + wc(k);
        end
        if (pend[k] && cyc == due[k]) begin
          automatic int idx = p_addr[k] % DEPTH;
          automatic bit bad = oor(p_addr[k]);
          if (p_write[k]) begin
            if (!bad) m_mem[k][idx] = p_data[k];
            e_rdata[k] = '0;
          end else begin
            e_rdata[k] = bad ? '0 : m_mem[k][idx];
          end
          e_err[k] = bad;
          pend[k]  = 1'b0;
          resp[k]  = 1'b1;
        end
      end
    end
    if (reset) armed = 1'b1;
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("d%0d req_ready", k), 64'(o_ready[k]),
            64'(!pend[k] && !resp[k]));
        chk($sformatf("d%0d rsp_valid", k), 64'(o_valid[k]),
            64'(resp[k]));
        chk($sformatf("d%0d busy", k), 64'(o_busy[k]),
            64'(pend[k] || resp[k]));
        if (resp[k]) begin
          chk($sformatf("d%0d rsp_rdata", k), 64'(o_rdata[k]),
              64'(e_rdata[k]));
          chk($sformatf("d%0d rsp_err", k), 64'(o_err[k]),
              64'(e_err[k]));
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!(o_ready[0] && o_ready[1]) && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) fail("wait_idle");
  endtask

  task automatic drive(input bit w, input int a, input logic [DW-1:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = AW'(a);
    req_wdata = d;
  endtask

  task automatic txn(input bit w, input int a, input logic [DW-1:0] d,
                     output logic [DW-1:0] rd, output logic er);
    int n = 0;
    wait_idle();
    rsp_ready = 1'b1;
    drive(w, a, d);
    @(negedge clk);
    req_valid = 1'b0;
    while (!o_valid[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) fail("txn rsp");
    rd = o_rdata[0];
    er = o_err[0];
    wait_idle();
  endtask

  logic [DW-1:0] rd;
  logic          er;

  initial begin
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    reset     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("t1 req_ready", 64'(o_ready[0]), 64'd1);
    chk("t1 rsp_valid", 64'(o_valid[0]), 64'd0);
    chk("t1 busy", 64'(o_busy[0]), 64'd0);
    chk("t1 rsp_rdata", 64'(o_rdata[0]), 64'd0);
    txn(1'b0, 0, '0, rd, er);
    chk("t1 read0", 64'(rd), 64'd0);

    wait_idle();
    rsp_ready = 1'b0;
    drive(1'b1, 5, 32'hDEADBEEF);
    @(negedge clk);
    req_valid = 1'b0;
    chk("t2 valid N+1", 64'(o_valid[0]), 64'd0);
    chk("t2 busy N+1", 64'(o_busy[0]), 64'd1);
    @(negedge clk);
    chk("t2 valid N+2", 64'(o_valid[0]), 64'd0);
    @(negedge clk);
    chk("t2 valid N+3", 64'(o_valid[0]), 64'd1);
    chk("t2 wr rdata", 64'(o_rdata[0]), 64'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("t2 ready after hs", 64'(o_ready[0]), 64'd1);
    txn(1'b0, 5, '0, rd, er);
    chk("t2 read5", 64'(rd), 64'hDEADBEEF);

    wait_idle();
    rsp_ready = 1'b0;
    drive(1'b0, 5, '0);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("t3 hold valid", 64'(o_valid[0]), 64'd1);
      chk("t3 hold rdata", 64'(o_rdata[0]), 64'hDEADBEEF);
      chk("t3 ready low", 64'(o_ready[0]), 64'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("t3 ready hs", 64'(o_ready[0]), 64'd1);
    chk("t3 valid hs", 64'(o_valid[0]), 64'd0);

    wait_idle();
    rsp_ready = 1'b1;
    drive(1'b1, 1, 32'h11111111);
    @(negedge clk);
    chk("t4 rsp1", 64'(o_valid[1]), 64'd1);
    chk("t4 ready1 low", 64'(o_ready[1]), 64'd0);
    req_addr  = 8'd2;
    req_wdata = 32'h22222222;
    @(negedge clk);
    chk("t4 ready1 back", 64'(o_ready[1]), 64'd1);
    @(negedge clk);
    chk("t4 rsp2", 64'(o_valid[1]), 64'd1);
    req_valid = 1'b0;
    wait_idle();

    txn(1'b1, 70, 32'h12345678, rd, er);
`ifdef PHASE1_ADDR_CHECK_EN
    chk("t5 err", 64'(er), 64'd1);
`else
    chk("t5 err", 64'(er), 64'd0);
`endif
    txn(1'b0, 6, '0, rd, er);
`ifdef PHASE1_ADDR_CHECK_EN
    chk("t5 read6", 64'(rd), 64'd0);
`else
    chk("t5 read6", 64'(rd), 64'h12345678);
`endif

    wait_idle();
    rsp_ready = 1'b0;
    drive(1'b1, 3, 32'hA5A5A5A5);
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t6 no rsp", 64'(o_valid[0]), 64'd0);
      @(negedge clk);
    end
    txn(1'b0, 3, '0, rd, er);
    chk("t6 read3", 64'(rd), 64'd0);

    for (int i = 0; i < 800; i++) begin
      reset     = ($urandom_range(0, 99) == 0);
      req_valid = $urandom_range(0, 2) != 0;
      req_write = $urandom_range(0, 1) == 1;
      req_addr  = AW'($urandom_range(0, 127));
      req_wdata = $urandom;
      rsp_ready = $urandom_range(0, 3) != 0;
      @(negedge clk);
    end
    reset = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (6) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
